// File: rtl/sys_cmd_ctrl.sv
// UART command-frame responder: parses AA/BB/CC/DD frames, drives register file and ALU, queues response bytes.
// Optional inter-byte timeout is compiled in with SYS_CMD_TIMEOUT_EN.
module sys_cmd_ctrl #(
    parameter int Data_width    = 8,
    parameter int Address_width = 4
`ifdef SYS_CMD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 500000
`endif
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [Data_width-1:0]     RX_P_DATA,
    input  logic                      RX_D_VLD,
    output logic [Address_width-1:0]  Address,
    output logic                      WrEn,
    output logic                      RdEn,
    output logic [Data_width-1:0]     WrData,
    input  logic [Data_width-1:0]     RdData,
    input  logic                      RdData_Valid,
    output logic                      ALU_EN,
    output logic [3:0]                ALU_FUN,
    input  logic [2*Data_width-1:0]   ALU_OUT,
    input  logic                      ALU_OUT_VLD,
    output logic [Data_width-1:0]     TX_P_DATA,
    output logic                      TX_D_VLD,
    input  logic                      FIFO_FULL,
    output logic                      FRAME_ERR
);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB,
        ALU_FUN_S, ALU_WAIT, TX_LO, TX_HI
    } state_e;

    state_e                     state_q, state_d;
    logic [Address_width-1:0]   addr_q, addr_d;
    logic [Data_width-1:0]      wr_data_q, wr_data_d;
    logic                       wr_en_q, wr_en_d;
    logic                       rd_en_q, rd_en_d;
    logic                       alu_en_q, alu_en_d;
    logic [3:0]                 alu_fun_q, alu_fun_d;
    logic [Data_width-1:0]      tx_data_q, tx_data_d;
    logic                       tx_vld_q, tx_vld_d;
    logic                       frame_err_q, frame_err_d;
    logic [Data_width-1:0]      hi_q, hi_d;
    logic                       is_alu_q, is_alu_d;

`ifdef SYS_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          in_parse;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        alu_en_d    = alu_en_q;
        alu_fun_d   = alu_fun_q;
        tx_data_d   = tx_data_q;
        tx_vld_d    = 1'b0;
        frame_err_d = 1'b0;
        hi_d        = hi_q;
        is_alu_d    = is_alu_q;
        case (state_q)
            IDLE: if (RX_D_VLD) begin
                if (RX_P_DATA == Data_width'(8'hAA))      state_d = WR_ADDR;
                else if (RX_P_DATA == Data_width'(8'hBB)) state_d = RD_ADDR;
                else if (RX_P_DATA == Data_width'(8'hCC)) state_d = OPA;
                else if (RX_P_DATA == Data_width'(8'hDD)) state_d = ALU_FUN_S;
                else                                      frame_err_d = 1'b1;
            end
            WR_ADDR: if (RX_D_VLD) begin
                addr_d  = RX_P_DATA[Address_width-1:0];
                state_d = WR_DATA;
            end
            WR_DATA: if (RX_D_VLD) begin
                wr_data_d = RX_P_DATA;
                wr_en_d   = 1'b1;
                state_d   = IDLE;
            end
            RD_ADDR: if (RX_D_VLD) begin
                addr_d  = RX_P_DATA[Address_width-1:0];
                rd_en_d = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                frame_err_d = RX_D_VLD;
                if (RdData_Valid) begin
                    tx_data_d = RdData;
                    is_alu_d  = 1'b0;
                    state_d   = TX_LO;
                end
            end
            OPA: if (RX_D_VLD) begin
                addr_d    = '0;
                wr_data_d = RX_P_DATA;
                wr_en_d   = 1'b1;
                state_d   = OPB;
            end
            OPB: if (RX_D_VLD) begin
                addr_d    = Address_width'(1);
                wr_data_d = RX_P_DATA;
                wr_en_d   = 1'b1;
                state_d   = ALU_FUN_S;
            end
            ALU_FUN_S: if (RX_D_VLD) begin
                alu_fun_d = RX_P_DATA[3:0];
                alu_en_d  = 1'b1;
                state_d   = ALU_WAIT;
            end
            ALU_WAIT: begin
                frame_err_d = RX_D_VLD;
                if (ALU_OUT_VLD) begin
                    alu_en_d  = 1'b0;
                    tx_data_d = ALU_OUT[Data_width-1:0];
                    hi_d      = ALU_OUT[2*Data_width-1:Data_width];
                    is_alu_d  = 1'b1;
                    state_d   = TX_LO;
                end
            end
            TX_LO: begin
                frame_err_d = RX_D_VLD;
                if (!FIFO_FULL) begin
                    tx_vld_d = 1'b1;
                    state_d  = is_alu_q ? TX_HI : IDLE;
                end
            end
            // Low byte is on the bus this cycle; swapping data now lines the high byte up with the next strobe.
            TX_HI: begin
                frame_err_d = RX_D_VLD;
                tx_data_d   = hi_q;
                if (!FIFO_FULL) begin
                    tx_vld_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef SYS_CMD_TIMEOUT_EN
        in_parse = (state_q == WR_ADDR) || (state_q == WR_DATA) || (state_q == RD_ADDR) ||
                   (state_q == OPA) || (state_q == OPB) || (state_q == ALU_FUN_S);
        tmo_d = '0;
        if (in_parse && !RX_D_VLD) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d     = IDLE;
                frame_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            alu_en_q    <= 1'b0;
            alu_fun_q   <= '0;
            tx_data_q   <= '0;
            tx_vld_q    <= 1'b0;
            frame_err_q <= 1'b0;
            hi_q        <= '0;
            is_alu_q    <= 1'b0;
`ifdef SYS_CMD_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            alu_en_q    <= alu_en_d;
            alu_fun_q   <= alu_fun_d;
            tx_data_q   <= tx_data_d;
            tx_vld_q    <= tx_vld_d;
            frame_err_q <= frame_err_d;
            hi_q        <= hi_d;
            is_alu_q    <= is_alu_d;
`ifdef SYS_CMD_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign Address   = addr_q;
    assign WrEn      = wr_en_q;
    assign RdEn      = rd_en_q;
    assign WrData    = wr_data_q;
    assign ALU_EN    = alu_en_q;
    assign ALU_FUN   = alu_fun_q;
    assign TX_P_DATA = tx_data_q;
    assign TX_D_VLD  = tx_vld_q;
    assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Scoreboard bench for sys_cmd_ctrl with register-file and ALU responders.
module tb_sys_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0;
    logic [3:0]  Address;
    logic        WrEn, RdEn;
    logic [7:0]  WrData;
    logic [7:0]  RdData = '0;
    logic        RdData_Valid = 1'b0;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_VLD = 1'b0;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        FIFO_FULL = 1'b0;
    logic        FRAME_ERR;

    sys_cmd_ctrl #(
        .Data_width(8),
        .Address_width(4)
`ifdef SYS_CMD_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
        .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_EN(ALU_EN),
        .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .FIFO_FULL(FIFO_FULL),
        .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [11:0] exp_wr[$];
    logic [7:0]  exp_tx[$];
    logic [3:0]  exp_fun[$];
    logic [7:0]  mem [16];
    int          tx_cnt = 0, fe_cnt = 0, fe_cyc = 0;
    int          tx_last_cyc = 0, tx_prev_cyc = 0;
    logic        alu_en_prev = 1'b0;
    logic [11:0] e_wr;
    logic [7:0]  e_tx;
    logic [3:0]  e_fun;

    // Monitor: pops scoreboard entries whenever the DUT produces a strobe.
    always @(negedge CLK) begin
        if (RST) begin
            if (WrEn) begin
                mem[Address] = WrData;
                check("wr_expected", 32'(exp_wr.size() != 0), 1);
                if (exp_wr.size() != 0) begin
                    e_wr = exp_wr.pop_front();
                    check("wr_addr_data", {20'd0, Address, WrData}, {20'd0, e_wr});
                end
            end
            if (TX_D_VLD) begin
                tx_cnt++;
                tx_prev_cyc = tx_last_cyc;
                tx_last_cyc = cyc;
                check("tx_expected", 32'(exp_tx.size() != 0), 1);
                if (exp_tx.size() != 0) begin
                    e_tx = exp_tx.pop_front();
                    check("tx_byte", {24'd0, TX_P_DATA}, {24'd0, e_tx});
                end
            end
            if (ALU_EN && !alu_en_prev) begin
                check("alu_expected", 32'(exp_fun.size() != 0), 1);
                if (exp_fun.size() != 0) begin
                    e_fun = exp_fun.pop_front();
                    check("alu_fun", {28'd0, ALU_FUN}, {28'd0, e_fun});
                end
            end
            if (FRAME_ERR) begin
                fe_cnt++;
                fe_cyc = cyc;
            end
            alu_en_prev = ALU_EN;
        end else begin
            alu_en_prev = 1'b0;
        end
    end

    // Register file model: one-cycle read latency.
    initial begin
        logic [3:0] ra;
        foreach (mem[i]) mem[i] = '0;
        forever begin
            @(negedge CLK);
            if (RST && RdEn) begin
                ra = Address;
                @(posedge CLK); #1;
                RdData = mem[ra];
                RdData_Valid = 1'b1;
                @(posedge CLK); #1;
                RdData_Valid = 1'b0;
            end
        end
    end

    int          alu_lat = 2;
    logic [15:0] alu_result = '0;
    logic        alu_seen = 1'b0;
    initial begin
        forever begin
            @(negedge CLK);
            if (RST && ALU_EN) begin
                repeat (alu_lat) @(posedge CLK);
                #1;
                ALU_OUT = alu_result;
                ALU_OUT_VLD = 1'b1;
                @(posedge CLK); #1;
                ALU_OUT_VLD = 1'b0;
                alu_seen = 1'b1;
            end
        end
    end

    int accept_cyc = 0;
    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK); #1;
        RX_P_DATA = b;
        RX_D_VLD = 1'b1;
        accept_cyc = cyc + 1;
        @(posedge CLK); #1;
        RX_D_VLD = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0 || exp_fun.size() != 0) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        repeat (4) @(negedge CLK);
        check({tag, "_tx_left"}, 32'(exp_tx.size()), 0);
        check({tag, "_wr_left"}, 32'(exp_wr.size()), 0);
        check({tag, "_fun_left"}, 32'(exp_fun.size()), 0);
    endtask

    initial begin
        int fe0, tx0, n;
        repeat (2) @(negedge CLK);
        check("rst_addr", {28'd0, Address}, 0);
        check("rst_wren", {31'd0, WrEn}, 0);
        check("rst_rden", {31'd0, RdEn}, 0);
        check("rst_wrdata", {24'd0, WrData}, 0);
        check("rst_aluen", {31'd0, ALU_EN}, 0);
        check("rst_alufun", {28'd0, ALU_FUN}, 0);
        check("rst_txdata", {24'd0, TX_P_DATA}, 0);
        check("rst_txvld", {31'd0, TX_D_VLD}, 0);
        check("rst_ferr", {31'd0, FRAME_ERR}, 0);
        @(posedge CLK); #1 RST = 1'b1;

        // Register write then read-back
        exp_wr.push_back({4'h5, 8'h55});
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h55);
        exp_tx.push_back(8'h55);
        send_byte(8'hBB); send_byte(8'h05);
        drain("wr_rd");

        // ALU with operands
        alu_lat = 2; alu_result = 16'h0023;
        exp_wr.push_back({4'h0, 8'h0A}); exp_wr.push_back({4'h1, 8'h19});
        exp_fun.push_back(4'h0);
        exp_tx.push_back(8'h23); exp_tx.push_back(8'h00);
        send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h19); send_byte(8'h00);
        drain("alu_cc");
        check("cc_hi_gap", 32'(tx_last_cyc - tx_prev_cyc), 1);

        // ALU on stored registers
        alu_result = 16'h002A;
        exp_fun.push_back(4'h2);
        exp_tx.push_back(8'h2A); exp_tx.push_back(8'h00);
        send_byte(8'hDD); send_byte(8'h02);
        drain("alu_dd");

        // Back-pressure while the response is pending
        FIFO_FULL = 1'b1;
        alu_seen = 1'b0;
        alu_result = 16'h0023;
        exp_wr.push_back({4'h0, 8'h0A}); exp_wr.push_back({4'h1, 8'h19});
        exp_fun.push_back(4'h0);
        exp_tx.push_back(8'h23); exp_tx.push_back(8'h00);
        send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h19); send_byte(8'h00);
        n = 0;
        while (!alu_seen && n < 100) begin @(negedge CLK); n++; end
        check("full_alu_seen", {31'd0, alu_seen}, 1);
        tx0 = tx_cnt;
        repeat (10) @(negedge CLK);
        check("full_hold", 32'(tx_cnt - tx0), 0);
        @(posedge CLK); #1 FIFO_FULL = 1'b0;
        drain("full");
        check("full_tx_count", 32'(tx_cnt - tx0), 2);
        check("full_hi_gap", 32'(tx_last_cyc - tx_prev_cyc), 1);

        // Protocol errors: unknown opcode, then a stray byte during ALU_WAIT
        fe0 = fe_cnt;
        send_byte(8'h7E);
        repeat (3) @(negedge CLK);
        check("ferr_idle", 32'(fe_cnt - fe0), 1);
        alu_lat = 8; alu_result = 16'h1234;
        exp_fun.push_back(4'h3);
        exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
        send_byte(8'hDD); send_byte(8'h03); send_byte(8'h11);
        drain("ferr_wait");
        check("ferr_wait_cnt", 32'(fe_cnt - fe0), 2);
        exp_wr.push_back({4'h7, 8'h3C});
        send_byte(8'hAA); send_byte(8'h07); send_byte(8'h3C);
        exp_tx.push_back(8'h3C);
        send_byte(8'hBB); send_byte(8'h07);
        drain("after_err");

        // Reset in the middle of a write frame
        send_byte(8'hAA); send_byte(8'h05);
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        check("midrst_addr", {28'd0, Address}, 0);
        check("midrst_wren", {31'd0, WrEn}, 0);
        @(posedge CLK); #1 RST = 1'b1;
        exp_tx.push_back(8'h55);
        send_byte(8'hBB); send_byte(8'h05);
        drain("midrst");

`ifdef SYS_CMD_TIMEOUT_EN
        fe0 = fe_cnt;
        send_byte(8'hAA);
        n = 0;
        while (fe_cnt == fe0 && n < 300) begin @(negedge CLK); n++; end
        check("tmo_ferr", 32'(fe_cnt - fe0), 1);
        check("tmo_cycle", 32'((fe_cyc - accept_cyc) >= 99 && (fe_cyc - accept_cyc) <= 101), 1);
        exp_tx.push_back(8'h55);
        send_byte(8'hBB); send_byte(8'h05);
        drain("tmo");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sys_cmd_ctrl.md
Name: sys_cmd_ctrl

Overview:
- Responder end of the UART command protocol: consumes received bytes, parses command frames, and drives the register file and ALU.
- Pushes response bytes into the TX FIFO.
- Sits in the Ref_clk domain between the RX data synchroniser and the register file, ALU and async TX FIFO.
- Frames: AA addr data (reg write); BB addr (reg read); CC opA opB fun (ALU with operands); DD fun (ALU on REG0/REG1).

Parameters:
Data_width, 8, byte / register width
Address_width, 4, register file address width
TIMEOUT_CYCLES, 500000, idle cycles between frame bytes before abort (only with SYS_CMD_TIMEOUT_EN)

Ports:
CLK  input  1  Ref_clk-domain clock
RST  input  1  asynchronous active-low reset
RX_P_DATA  input  Data_width  received byte
RX_D_VLD  input  1  one-cycle pulse per received byte
Address  output  Address_width  register file address
WrEn  output  1  register write strobe
RdEn  output  1  register read strobe
WrData  output  Data_width  register write data
RdData  input  Data_width  register read data
RdData_Valid  input  1  read data valid pulse
ALU_EN  output  1  ALU enable, held until ALU_OUT_VLD
ALU_FUN  output  4  ALU function
ALU_OUT  input  2*Data_width  ALU result
ALU_OUT_VLD  input  1  ALU result valid pulse
TX_P_DATA  output  Data_width  byte to TX FIFO
TX_D_VLD  output  1  TX FIFO write strobe
FIFO_FULL  input  1  TX FIFO full
FRAME_ERR  output  1  one-cycle pulse on protocol error

Behaviour:
- Reset (RST low, asynchronous): state IDLE; all outputs 0 (Address, WrData, ALU_FUN, TX_P_DATA cleared; all strobes low).
- All outputs are registered.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, ALU_FUN_S, ALU_WAIT, TX_LO, TX_HI.
- IDLE, on RX_D_VLD:
  - AA -> WR_ADDR; BB -> RD_ADDR; CC -> OPA; DD -> ALU_FUN_S.
  - Any other byte: stay IDLE, FRAME_ERR pulse.
- WR_ADDR: latch Address=RX_P_DATA[Address_width-1:0]; upper bits ignored.
- WR_DATA: on byte, WrData=byte, WrEn high exactly one cycle the next cycle; return to IDLE. No response byte.
- RD_ADDR: latch address; RdEn high one cycle; -> RD_WAIT.
- RD_WAIT: on RdData_Valid, capture RdData into TX_P_DATA -> TX_LO.
- OPA: write byte to address 0 (one-cycle WrEn) -> OPB.
- OPB: write byte to address 1 (one-cycle WrEn) -> ALU_FUN_S.
- ALU_FUN_S: on byte, ALU_FUN=byte[3:0], ALU_EN high -> ALU_WAIT.
- ALU_WAIT: on ALU_OUT_VLD, drop ALU_EN, capture ALU_OUT -> TX_LO then TX_HI.
- TX_LO / TX_HI handshake:
  - Issue TX_D_VLD for one cycle only while FIFO_FULL=0; otherwise hold data and state.
  - ALU responses: TX_LO sends ALU_OUT[7:0], TX_HI sends ALU_OUT[15:8], then IDLE.
  - Read responses: TX_LO only, then IDLE.
- Bytes arriving in RD_WAIT, ALU_WAIT, TX_LO or TX_HI are dropped with a FRAME_ERR pulse; state is unaffected.
- Simultaneous RX_D_VLD and RdData_Valid/ALU_OUT_VLD: the result is captured and the byte is dropped (FRAME_ERR).
- Response latency:
  - Read: TX_D_VLD at least 1 cycle after RdData_Valid.
  - ALU low byte: at least 1 cycle after ALU_OUT_VLD; high byte exactly 1 cycle after the low byte if FIFO not full.
- Reset mid-frame: immediate return to IDLE; no partial write is committed.

Optional Feature:
- Macro: SYS_CMD_TIMEOUT_EN.
- Defined:
  - Counter resets on every RX_D_VLD and runs in WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, ALU_FUN_S.
  - Reaching TIMEOUT_CYCLES -> IDLE plus a FRAME_ERR pulse; no strobes are issued.
  - Wait states and TX states never time out.
- Undefined: no counter; partial frames wait indefinitely.

Test Plan:
- AA,05,55 then BB,05 -> one WrEn (Address=5, WrData=0x55); later a single TX_D_VLD with TX_P_DATA=0x55.
- CC,0A,19,00 with ALU_OUT=0x0023 -> WrEn to addr0=0x0A and addr1=0x19, ALU_FUN=0; TX bytes 0x23 then 0x00.
- DD,02 with ALU_OUT=0x002A -> no WrEn, ALU_EN with ALU_FUN=2; TX 0x2A, 0x00.
- FIFO_FULL held high 10 cycles during TX_LO -> no TX_D_VLD until released; then 0x23,0x00 in consecutive cycles.
- Byte 0x7E in IDLE, and byte 0x11 during ALU_WAIT -> FRAME_ERR pulses; state unchanged; following AA frame works.
- RST low after AA,05 -> IDLE, no WrEn. With SYS_CMD_TIMEOUT_EN (TIMEOUT_CYCLES=100), AA then silence -> FRAME_ERR at cycle 100; next BB,05 returns stored data.
